// File: rtl/spi_m_tx.sv
// spi_m_tx - SPI master transmitter (mode 0, MSB first) feeding pixel bytes
// from a host valid/ready stream into the memory LCD driver's SPI receiver.
//
// Build option:
//   SPI_M_TX_CTS_EN  defined   : i_spi_cts is double-flopped and gates o_tx_ready.
//                    undefined : i_spi_cts is ignored and the receiver is always
//                                treated as clear to send.
//
// Ports:
//   i_clk       system clock
//   i_reset     asynchronous active-high reset
//   i_tx_data   byte to send (sampled only in the handshake cycle)
//   i_tx_valid  i_tx_data valid
//   o_tx_ready  byte accepted this cycle when i_tx_valid && o_tx_ready
//   i_spi_cts   receiver clear-to-send, asynchronous
//   o_spi_clk   SCLK, idle low
//   o_spi_mosi  serial data, changes on SCLK falling edges
//   o_spi_cs_n  chip select, active low
//   o_tx_done   one-cycle pulse per completed byte
//   o_busy      high whenever the FSM is not idle
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | CS high, SCLK low, waiting for a handshake
// SETUP | CS low, first MOSI bit set up for one half-period before SCLK rises
// SHIFT | clocking bits out; byte boundary on the falling edge after bit 0
// HOLD  | CS low, SCLK low for one half-period after the last bit
// GAP   | CS high for one half-period before a new frame may start

module spi_m_tx #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_spi_cts,
  output logic       o_spi_clk,
  output logic       o_spi_mosi,
  output logic       o_spi_cs_n,
  output logic       o_tx_done,
  output logic       o_busy
);

  localparam int PW = $clog2(HALF_PERIOD);
  localparam logic [PW-1:0] PH_LOAD = PW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          drain_q, drain_d;

  logic          cts_s;
  logic          phase_tc;
  logic          at_boundary;
  logic          ready_int;
  logic          hs;

`ifdef SPI_M_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cts_meta_q <= 1'b0;
      cts_sync_q <= 1'b0;
    end else begin
      cts_meta_q <= i_spi_cts;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_s = cts_sync_q;
`else
  logic unused_cts;
  assign unused_cts = i_spi_cts;
  assign cts_s      = 1'b1;
`endif

  assign phase_tc = (phase_q == '0);

  // Byte boundary: last cycle of bit 0's high half, i.e. the cycle whose
  // closing edge produces the falling SCLK edge after bit 0.
  assign at_boundary = (state_q == S_SHIFT) && sclk_q && phase_tc &&
                       (bit_q == 3'd0);

  // Reset gating keeps ready low during reset even when CTS is tied high.
  assign ready_int  = cts_s && ((state_q == S_IDLE) || at_boundary);
  assign o_tx_ready = ready_int && !i_reset;
  assign hs         = i_tx_valid && o_tx_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    drain_d = drain_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (hs) begin
          shift_d = i_tx_data;
          mosi_d  = i_tx_data[7];
          cs_n_d  = 1'b0;
          bit_d   = 3'd7;
          phase_d = PH_LOAD;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (phase_tc) begin
          sclk_d  = 1'b1;
          phase_d = PH_LOAD;
          state_d = S_SHIFT;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      S_SHIFT: begin
        if (!phase_tc) begin
          phase_d = phase_q - PW'(1);
        end else begin
          phase_d = PH_LOAD;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != 3'd0) begin
              bit_d   = bit_q - 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              mosi_d  = shift_q[6];
            end else begin
              done_d = 1'b1;
              if (hs) begin
                shift_d = i_tx_data;
                mosi_d  = i_tx_data[7];
                bit_d   = 3'd7;
              end else begin
                // Finish bit 0's low half before HOLD so the frame
                // keeps its full 16 half-periods of bit time.
                drain_d = 1'b1;
              end
            end
          end else if (drain_q) begin
            drain_d = 1'b0;
            state_d = S_HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (phase_tc) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          phase_d = PH_LOAD;
          state_d = S_GAP;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      S_GAP: begin
        if (phase_tc) begin
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        drain_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      phase_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      drain_q <= drain_d;
    end
  end

  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_cs_n = cs_n_q;
  assign o_tx_done  = done_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_m_tx.sv
// tb_spi_m_tx - directed bench for spi_m_tx with HALF_PERIOD = 4.
// Bytes are pushed to a scoreboard at each handshake; a monitor rebuilds the
// byte from MOSI at SCLK rises and pops/compares on every o_tx_done pulse.

module tb_spi_m_tx;

  localparam int HP = 4;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       i_spi_cts;
  logic       o_spi_clk;
  logic       o_spi_mosi;
  logic       o_spi_cs_n;
  logic       o_tx_done;
  logic       o_busy;

  spi_m_tx #(.HALF_PERIOD(HP)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .i_spi_cts  (i_spi_cts),
    .o_spi_clk  (o_spi_clk),
    .o_spi_mosi (o_spi_mosi),
    .o_spi_cs_n (o_spi_cs_n),
    .o_tx_done  (o_tx_done),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_byte   = 8'h00;
  int cyc          = 0;
  int bitc         = 0;
  int rise_cnt     = 0;
  int done_cnt     = 0;
  int cs_rises     = 0;
  int cs_low_run   = 0;
  int last_low_len = 0;
  logic sclk_prev  = 1'b0;
  logic cs_prev    = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard, sampling on the inactive edge.
  always @(negedge i_clk) begin
    cyc++;
    if (i_reset) begin
      bitc       = 0;
      sclk_prev  = 1'b0;
      cs_prev    = 1'b1;
      cs_low_run = 0;
    end else begin
      if (o_spi_clk && !sclk_prev) begin
        rx_byte = {rx_byte[6:0], o_spi_mosi};
        bitc++;
        rise_cnt++;
      end
      if (o_tx_done) begin
        int qs;
        done_cnt++;
        check("bits_per_byte", 32'(bitc), 32'd8);
        qs = exp_q.size();
        check("sb_nonempty", 32'(qs != 0), 32'd1);
        if (qs != 0) check("byte_data", 32'(rx_byte), 32'(exp_q.pop_front()));
        bitc = 0;
      end
      if (!o_spi_cs_n) cs_low_run++;
      if (o_spi_cs_n && !cs_prev) begin
        last_low_len = cs_low_run;
        cs_low_run   = 0;
        cs_rises++;
      end
      if (i_tx_valid && o_tx_ready) exp_q.push_back(i_tx_data);
      sclk_prev = o_spi_clk;
      cs_prev   = o_spi_cs_n;
    end
  end

  task automatic nclk();
    @(negedge i_clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_counts();
    rise_cnt = 0;
    done_cnt = 0;
    cs_rises = 0;
  endtask

  task automatic wait_hs(output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 400; i++) begin
      nclk();
      if (i_tx_valid && o_tx_ready) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
    check("hs_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_cs_high();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      nclk();
      if (o_spi_cs_n) begin
        ok = 1'b1;
        break;
      end
    end
    check("cs_high_seen", 32'(ok), 32'd1);
  endtask

  int c0, c1, c2, n;

  initial begin
    i_reset    = 1'b1;
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b0;
    i_spi_cts  = 1'b1;
    repeat (3) nclk();
    check("rst_cs_n",  32'(o_spi_cs_n), 32'd1);
    check("rst_sclk",  32'(o_spi_clk),  32'd0);
    check("rst_mosi",  32'(o_spi_mosi), 32'd0);
    check("rst_ready", 32'(o_tx_ready), 32'd0);
    check("rst_done",  32'(o_tx_done),  32'd0);
    check("rst_busy",  32'(o_busy),     32'd0);
    drive_edge();
    i_reset = 1'b0;
    repeat (3) drive_edge();

    // Single byte 0xA5.
    clear_counts();
    i_tx_data  = 8'hA5;
    i_tx_valid = 1'b1;
    wait_hs(c0);
    check("a5_cs_before_hs", 32'(o_spi_cs_n), 32'd1);
    drive_edge();
    i_tx_valid = 1'b0;
    nclk();
    check("a5_cs_fall", 32'(o_spi_cs_n), 32'd0);
    n = 0;
    for (int i = 0; i < 20 && !o_spi_clk; i++) begin
      nclk();
      n++;
    end
    check("a5_first_rise", 32'(n), 32'(HP));
    wait_cs_high();
    check("a5_low_len", 32'(last_low_len), 32'(18 * HP));
    n = 0;
    for (int i = 0; i < 20 && o_busy; i++) begin
      n++;
      nclk();
    end
    check("a5_gap_len", 32'(n), 32'(HP));
    check("a5_rises", 32'(rise_cnt), 32'd8);
    check("a5_done",  32'(done_cnt), 32'd1);

    // Burst 0x01, 0x02, 0x03 with valid held.
    repeat (2) drive_edge();
    clear_counts();
    i_tx_data  = 8'h01;
    i_tx_valid = 1'b1;
    wait_hs(c0);
    drive_edge();
    i_tx_data = 8'h02;
    wait_hs(c1);
    drive_edge();
    i_tx_data = 8'h03;
    wait_hs(c2);
    drive_edge();
    i_tx_valid = 1'b0;
    check("burst_space1", 32'(c1 - c0), 32'(16 * HP));
    check("burst_space2", 32'(c2 - c1), 32'(16 * HP));
    wait_cs_high();
    check("burst_low_len", 32'(last_low_len), 32'(18 * HP + 32 * HP));
    check("burst_cs_rises", 32'(cs_rises), 32'd1);
    repeat (2 * HP) nclk();
    check("burst_rises", 32'(rise_cnt), 32'd24);
    check("burst_done",  32'(done_cnt), 32'd3);

    // Reset mid-byte after 3 SCLK rises.
    repeat (2) drive_edge();
    clear_counts();
    i_tx_data  = 8'h77;
    i_tx_valid = 1'b1;
    wait_hs(c0);
    drive_edge();
    i_tx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && rise_cnt < 3; i++) nclk();
    check("rst_mid_rises", 32'(rise_cnt), 32'd3);
    drive_edge();
    i_reset = 1'b1;
    #1;
    check("rst_mid_cs_n", 32'(o_spi_cs_n), 32'd1);
    check("rst_mid_sclk", 32'(o_spi_clk),  32'd0);
    check("rst_mid_mosi", 32'(o_spi_mosi), 32'd0);
    repeat (3) nclk();
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    exp_q.delete();
    drive_edge();
    i_reset = 1'b0;
    repeat (4 * HP) nclk();
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    drive_edge();
    clear_counts();
    i_tx_data  = 8'h3C;
    i_tx_valid = 1'b1;
    wait_hs(c0);
    drive_edge();
    i_tx_valid = 1'b0;
    wait_cs_high();
    check("post_rst_low_len", 32'(last_low_len), 32'(18 * HP));
    repeat (2 * HP) nclk();
    check("post_rst_done", 32'(done_cnt), 32'd1);

`ifdef SPI_M_TX_CTS_EN
    // CTS low holds off the handshake; ready follows CTS two cycles later.
    repeat (2) drive_edge();
    clear_counts();
    i_spi_cts  = 1'b0;
    repeat (4) drive_edge();
    i_tx_data  = 8'h96;
    i_tx_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      nclk();
      if (o_tx_ready || !o_spi_cs_n) n++;
    end
    check("cts_lo_blocked", 32'(n), 32'd0);
    i_spi_cts = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && !o_tx_ready; i++) begin
      nclk();
      n++;
    end
    check("cts_latency", 32'(n), 32'd2);
    drive_edge();
    i_tx_valid = 1'b0;
    wait_cs_high();
    repeat (2 * HP) nclk();
    check("cts_done", 32'(done_cnt), 32'd1);

    // CTS drops in the middle of byte 2 of a 3-byte burst.
    clear_counts();
    i_tx_data  = 8'h11;
    i_tx_valid = 1'b1;
    wait_hs(c0);
    drive_edge();
    i_tx_data = 8'h22;
    wait_hs(c1);
    drive_edge();
    i_tx_data = 8'h33;
    repeat (8 * HP) nclk();
    i_spi_cts = 1'b0;
    wait_cs_high();
    repeat (2) nclk();
    check("cts_drop_done", 32'(done_cnt), 32'd2);
    check("cts_drop_frames", 32'(cs_rises), 32'd1);
    i_spi_cts = 1'b1;
    wait_hs(c2);
    drive_edge();
    i_tx_valid = 1'b0;
    wait_cs_high();
    repeat (2 * HP) nclk();
    check("cts_resume_done", 32'(done_cnt), 32'd3);
    check("cts_resume_frames", 32'(cs_rises), 32'd2);
`else
    // Without the CTS option, a low CTS input must not hold anything off.
    repeat (2) drive_edge();
    clear_counts();
    i_spi_cts  = 1'b0;
    i_tx_data  = 8'h5A;
    i_tx_valid = 1'b1;
    wait_hs(c0);
    drive_edge();
    i_tx_valid = 1'b0;
    wait_cs_high();
    check("nocts_low_len", 32'(last_low_len), 32'(18 * HP));
    repeat (2 * HP) nclk();
    check("nocts_rises", 32'(rise_cnt), 32'd8);
    check("nocts_done",  32'(done_cnt), 32'd1);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
